out_port_arb: RTL and testbench
===============================

OUT_PORT_ARB -- requirements
Module: out_port_arb

Interface
REQ-001 SHALL have parameter PYLD_W, default 23, meaning payload width per requester.
REQ-002 SHALL have parameter OUT_DIR, default 3'd0, meaning the direction this output port serves (N=0, W=1, S=2, E=3, B=4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 5 bits: per-input-buffer arbitration request (bit i from input port i).
REQ-006 SHALL have port payload_i, input, 5*PYLD_W bits: slice i is the payload of input port i, stable while req[i]=1.
REQ-007 SHALL have port gnt, output, 5 bits: one-hot-or-zero grant, registered.
REQ-008 SHALL have port pg_en, input, 1 bit: fault handling enable.
REQ-009 SHALL have port dst_fault, input, 1 bit: downstream node on OUT_DIR is faulty.
REQ-010 SHALL have port port_rdy, output, 1 bit: ready broadcast to all input buffers.
REQ-011 SHALL have port obuf_vld, output, 1 bit: valid to output buffer.
REQ-012 SHALL have port obuf_rdy, input, 1 bit: output buffer ready.
REQ-013 SHALL have port obuf_payload, output, PYLD_W bits: registered selected payload.

Function
REQ-014 SHALL treat effective requests as ereq = req with bit OUT_DIR forced to 0 (no U-turn).
REQ-015 SHALL implement two states: IDLE (gnt=0) and HOLD (gnt=one-hot winner).
REQ-016 SHALL define drop = pg_en & dst_fault, evaluated combinationally every cycle.
REQ-017 SHALL drive obuf_vld = (state==HOLD) & ~drop; port_rdy = obuf_rdy | drop.
REQ-018 SHALL define xfer = (state==HOLD) & (obuf_rdy | drop); xfer completes the granted transaction.
REQ-019 SHALL pick the winner round-robin: first set bit of candidate vector searching ptr, ptr+1, ... modulo 5.
REQ-020 IDLE: if ereq!=0, next cycle gnt=winner(ereq), obuf_payload=payload_i slice of winner, state HOLD; else stay IDLE. Latency req->gnt: 1 cycle.
REQ-021 HOLD without xfer: gnt, obuf_payload, ptr unchanged, even if the granted req drops or other reqs rise.
REQ-022 HOLD with xfer from port k: ptr <= (k+1) mod 5; candidates = ereq & ~gnt; if non-zero, grant next winner (searched from the new ptr) with payload capture, stay HOLD (back-to-back, one transfer per cycle); else gnt <= 0, state IDLE.
REQ-023 Drop mid-HOLD SHALL complete the current grant that cycle with obuf_vld=0 (packet absorbed); drop deasserting mid-HOLD resumes normal handshake without losing the grant.
REQ-024 SHALL never assert more than one gnt bit; gnt[OUT_DIR] SHALL never be 1.
REQ-025 obuf_payload SHALL change only on a grant capture.

Reset
REQ-026 On rst_n=0, immediately: state IDLE, gnt=0, ptr=0, obuf_payload=0; hence obuf_vld=0.
REQ-027 Reset mid-HOLD SHALL discard the in-flight grant; no transfer reported after release until a new grant.

Structure
REQ-028 Direction codes DIR_N..DIR_B and port count 5 SHALL live in the shared mesh package, shared with the input-buffer controller.
REQ-029 Round-robin priority encoder (5-bit vector, 3-bit ptr -> one-hot) SHALL be sub-module rr_pick5, combinational.

Verification
REQ-030 OUT_DIR=3, req=5'b00101, obuf_rdy=1 -> gnt=00001 in cycle 1, 00100 in cycle 2, then 00001 again, ptr advancing 1,3,1.
REQ-031 req=5'b01000 with OUT_DIR=3 -> gnt stays 0, obuf_vld stays 0.
REQ-032 gnt=00010 held, obuf_rdy=0 for 4 cycles then 1 -> gnt, obuf_payload stable 4 cycles, transfer on 5th, port_rdy follows obuf_rdy.
REQ-033 pg_en=1, dst_fault=1, obuf_rdy=0, req=10000 -> gnt=10000 for one cycle, port_rdy=1, obuf_vld=0, return IDLE.
REQ-034 Assert rst_n=0 while HOLD with gnt=00100 -> gnt=0, obuf_payload=0 same cycle; after release, req=00100 regranted after 1 cycle.
REQ-035 Random req/obuf_rdy/drop for 10k cycles -> gnt one-hot-or-zero, no starvation beyond 4 transfers per waiting requester.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh definitions: direction codes, port count and helpers used by
// the output-port arbiter and the input-buffer controller.
package mesh_pkg;

   localparam int NUM_PORTS = 5;
   localparam int DIR_BITS  = 3;

   typedef enum logic [DIR_BITS-1:0] {
      DIR_N = 3'd0,
      DIR_W = 3'd1,
      DIR_S = 3'd2,
      DIR_E = 3'd3,
      DIR_B = 3'd4
   } dir_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   // Port index following k in the 0..4 ring.
   function automatic logic [DIR_BITS-1:0] next_ptr(input logic [DIR_BITS-1:0] k);
      return (k >= 3'd4) ? 3'd0 : k + 3'd1;
   endfunction

   function automatic logic [DIR_BITS-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
      logic [DIR_BITS-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/out_port_arb_rr_pick5.sv
// Combinational round-robin picker: returns the first set bit of cand
// found by walking ptr, ptr+1, ... around the five-port ring.
module rr_pick5
   import mesh_pkg::*;
(
   input  logic [NUM_PORTS-1:0] cand,
   input  logic [DIR_BITS-1:0]  ptr,
   output logic [NUM_PORTS-1:0] pick
);

   logic [DIR_BITS-1:0] start;
   logic [DIR_BITS:0]   sum;
   logic [DIR_BITS-1:0] idx;
   logic                found;

   // An out-of-range pointer is treated as port 0 so the search stays on the ring.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      start = (ptr > 3'd4) ? 3'd0 : ptr;
      for (int off = 0; off < NUM_PORTS; off++) begin
         sum = {1'b0, start} + 4'(off);
         idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[DIR_BITS-1:0];
         if (!found && cand[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/out_port_arb.sv
// Output-port arbiter: round-robin grants among the five input buffers,
// registered payload capture, and fault-driven packet dropping.
module out_port_arb
   import mesh_pkg::*;
#(
   parameter int                  PYLD_W  = 23,
   parameter logic [DIR_BITS-1:0] OUT_DIR = 3'd0
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS*PYLD_W-1:0]   payload_i,
   output logic [NUM_PORTS-1:0]          gnt,
   input  logic                          pg_en,
   input  logic                          dst_fault,
   output logic                          port_rdy,
   output logic                          obuf_vld,
   input  logic                          obuf_rdy,
   output logic [PYLD_W-1:0]             obuf_payload
);

   localparam logic [NUM_PORTS-1:0] UTURN_MASK = 5'b00001 << OUT_DIR;

   arb_state_e            state;
   logic [DIR_BITS-1:0]   ptr;
   logic [NUM_PORTS-1:0]  ereq;
   logic                  drop;
   logic                  xfer;
   logic [NUM_PORTS-1:0]  cand;
   logic [DIR_BITS-1:0]   search_ptr;
   logic [NUM_PORTS-1:0]  pick;
   logic [PYLD_W-1:0]     pick_payload;

   assign ereq     = req & ~UTURN_MASK;
   assign drop     = pg_en & dst_fault;
   assign xfer     = (state == ARB_HOLD) & (obuf_rdy | drop);
   assign obuf_vld = (state == ARB_HOLD) & ~drop;
   assign port_rdy = obuf_rdy | drop;

   // On a completing transfer the search restarts just past the served port,
   // and the served port is excluded so it cannot win twice in a row.
   always_comb begin
      cand       = ereq;
      search_ptr = ptr;
      if (state == ARB_HOLD) begin
         cand = ereq & ~gnt;
         if (xfer) search_ptr = next_ptr(onehot_to_idx(gnt));
      end
   end

   rr_pick5 u_pick (
      .cand (cand),
      .ptr  (search_ptr),
      .pick (pick)
   );

   always_comb begin
      pick_payload = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pick[i]) pick_payload = pick_payload | payload_i[i*PYLD_W +: PYLD_W];
      end
   end

   // Grant, pointer and payload only move on a capture or a completed transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         gnt          <= '0;
         ptr          <= '0;
         obuf_payload <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|ereq) begin
                  gnt          <= pick;
                  obuf_payload <= pick_payload;
                  state        <= ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (xfer) begin
                  ptr <= search_ptr;
                  if (|cand) begin
                     gnt          <= pick;
                     obuf_payload <= pick_payload;
                  end else begin
                     gnt   <= '0;
                     state <= ARB_IDLE;
                  end
               end
            end
            default: begin
               gnt   <= '0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_arb.sv
// Self-checking bench for out_port_arb: directed scenarios with literal
// expectations plus randomized traffic compared against a ring-search model.
module tb_out_port_arb;
   import mesh_pkg::*;

   localparam int              PYLD_W  = 23;
   localparam logic [2:0]      OUT_DIR = 3'd3;
   localparam int              CHK_DIR = 3;

   logic                        clk;
   logic                        rst_n;
   logic [4:0]                  req;
   logic [5*PYLD_W-1:0]         payload_i;
   logic [4:0]                  gnt;
   logic                        pg_en;
   logic                        dst_fault;
   logic                        port_rdy;
   logic                        obuf_vld;
   logic                        obuf_rdy;
   logic [PYLD_W-1:0]           obuf_payload;

   int checks = 0;
   int errors = 0;

   bit                m_busy = 1'b0;
   int                m_k = 0;
   int                m_ptr = 0;
   logic [PYLD_W-1:0] m_payload = '0;
   int                wait_cnt [5] = '{default: 0};

   out_port_arb #(.PYLD_W(PYLD_W), .OUT_DIR(OUT_DIR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .payload_i    (payload_i),
      .gnt          (gnt),
      .pg_en        (pg_en),
      .dst_fault    (dst_fault),
      .port_rdy     (port_rdy),
      .obuf_vld     (obuf_vld),
      .obuf_rdy     (obuf_rdy),
      .obuf_payload (obuf_payload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [4:0] r, input logic rdy, input logic pg, input logic flt);
      @(posedge clk);
      #1;
      req       = r;
      obuf_rdy  = rdy;
      pg_en     = pg;
      dst_fault = flt;
   endtask

   function automatic int rr_winner(input logic [4:0] v, input int p);
      for (int off = 0; off < 5; off++) begin
         if (v[(p + off) % 5]) return (p + off) % 5;
      end
      return 0;
   endfunction

   function automatic logic [PYLD_W-1:0] slice_of(input int i);
      return payload_i[i*PYLD_W +: PYLD_W];
   endfunction

   // Reference model: one granted port at a time, served in ring order.
   always @(posedge clk or negedge rst_n) begin
      logic [4:0] er;
      logic [4:0] rem;
      if (!rst_n) begin
         m_busy    = 1'b0;
         m_k       = 0;
         m_ptr     = 0;
         m_payload = '0;
         for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
      end else begin
         er          = req;
         er[CHK_DIR] = 1'b0;
         if (!m_busy) begin
            if (er != 5'b0) begin
               m_k       = rr_winner(er, m_ptr);
               m_busy    = 1'b1;
               m_payload = slice_of(m_k);
            end
         end else if (obuf_rdy || (pg_en && dst_fault)) begin
            for (int i = 0; i < 5; i++) begin
               if (i != m_k && er[i]) begin
                  wait_cnt[i]++;
                  checks++;
                  if (wait_cnt[i] > 4) begin
                     errors++;
                     $display("[TB] FAIL starvation port %0d: waited %0d transfers, limit 4", i, wait_cnt[i]);
                  end
               end
            end
            m_ptr    = (m_k + 1) % 5;
            rem      = er;
            rem[m_k] = 1'b0;
            if (rem != 5'b0) begin
               m_k       = rr_winner(rem, m_ptr);
               m_payload = slice_of(m_k);
            end else begin
               m_busy = 1'b0;
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (!er[i] || (m_busy && i == m_k)) wait_cnt[i] = 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [4:0] exp_gnt;
      logic       drp;
      drp     = pg_en & dst_fault;
      exp_gnt = m_busy ? (5'b00001 << m_k) : 5'b00000;
      check_output("model_gnt", 32'(gnt), 32'(exp_gnt));
      check_output("model_obuf_vld", 32'(obuf_vld), 32'(m_busy & ~drp));
      check_output("model_port_rdy", 32'(port_rdy), 32'(obuf_rdy | drp));
      check_output("model_payload", 32'(obuf_payload), 32'(m_payload));
      check_output("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      check_output("gnt_no_uturn", 32'(gnt[CHK_DIR]), 32'd0);
   end

   initial begin
      logic [4:0] nreq;
      rst_n     = 1'b0;
      req       = '0;
      obuf_rdy  = 1'b0;
      pg_en     = 1'b0;
      dst_fault = 1'b0;
      for (int i = 0; i < 5; i++) payload_i[i*PYLD_W +: PYLD_W] = 23'h100 + 23'(i);

      @(negedge clk);
      check_output("reset_gnt", 32'(gnt), 32'h0);
      check_output("reset_payload", 32'(obuf_payload), 32'h0);
      check_output("reset_vld", 32'(obuf_vld), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Alternating grants between ports 0 and 2
      apply_stimulus(5'b00101, 1'b1, 1'b0, 1'b0);
      @(negedge clk); check_output("rr_latency_gnt", 32'(gnt), 32'h00);
      @(negedge clk); check_output("rr_gnt1", 32'(gnt), 32'h01);
      check_output("rr_payload1", 32'(obuf_payload), 32'h100);
      @(negedge clk); check_output("rr_gnt2", 32'(gnt), 32'h04);
      check_output("rr_payload2", 32'(obuf_payload), 32'h102);
      @(negedge clk); check_output("rr_gnt3", 32'(gnt), 32'h01);
      apply_stimulus(5'b00000, 1'b1, 1'b0, 1'b0);
      @(negedge clk); check_output("rr_gnt4", 32'(gnt), 32'h04);
      @(negedge clk); check_output("rr_idle_gnt", 32'(gnt), 32'h00);

      // Request from the served direction itself is ignored
      apply_stimulus(5'b01000, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check_output("uturn_gnt", 32'(gnt), 32'h00);
         check_output("uturn_vld", 32'(obuf_vld), 32'h0);
      end

      // Backpressure holds the grant for four cycles
      apply_stimulus(5'b00010, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         check_output("hold_gnt", 32'(gnt), 32'h02);
         check_output("hold_payload", 32'(obuf_payload), 32'h101);
         check_output("hold_port_rdy", 32'(port_rdy), 32'h0);
         check_output("hold_vld", 32'(obuf_vld), 32'h1);
      end
      apply_stimulus(5'b00000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_output("hold_xfer_gnt", 32'(gnt), 32'h02);
      check_output("hold_xfer_port_rdy", 32'(port_rdy), 32'h1);
      @(negedge clk); check_output("hold_release_gnt", 32'(gnt), 32'h00);

      // Faulty downstream: packet absorbed without a valid
      apply_stimulus(5'b10000, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_output("drop_idle_gnt", 32'(gnt), 32'h00);
      check_output("drop_idle_port_rdy", 32'(port_rdy), 32'h1);
      apply_stimulus(5'b00000, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_output("drop_gnt", 32'(gnt), 32'h10);
      check_output("drop_vld", 32'(obuf_vld), 32'h0);
      check_output("drop_port_rdy", 32'(port_rdy), 32'h1);
      @(negedge clk); check_output("drop_return_gnt", 32'(gnt), 32'h00);

      // Reset in the middle of a held grant
      apply_stimulus(5'b00100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_output("prereset_gnt", 32'(gnt), 32'h04);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_output("midreset_gnt", 32'(gnt), 32'h00);
      check_output("midreset_payload", 32'(obuf_payload), 32'h0);
      check_output("midreset_vld", 32'(obuf_vld), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_output("postreset_gnt", 32'(gnt), 32'h00);
      check_output("postreset_vld", 32'(obuf_vld), 32'h0);
      @(negedge clk); check_output("regrant_gnt", 32'(gnt), 32'h04);
      apply_stimulus(5'b00000, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Randomized traffic with sticky requests
      repeat (10000) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 5; i++) begin
            if (req[i]) nreq[i] = ($urandom_range(0, 7) != 0);
            else        nreq[i] = ($urandom_range(0, 2) == 0);
            if (!(req[i] && nreq[i])) payload_i[i*PYLD_W +: PYLD_W] = PYLD_W'($urandom);
         end
         req       = nreq;
         obuf_rdy  = ($urandom_range(0, 3) != 0);
         pg_en     = $urandom_range(0, 1) == 1;
         dst_fault = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
